data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target end of the core's load/store interface.
- Accepts word requests over a valid/ready handshake and applies a programmable number of wait states.
- Performs byte-enabled writes or word reads, then returns a response over a second valid/ready handshake.
- Replaces the zero-latency data memory when the core moves to a stall-capable memory path.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/data_mem_responder_if.sv | 30 +++
 rtl/dmem_array.sv | 33 +++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared FSM encoding and address-check helpers for the responder
// Revision: 1.0
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES   = 4;
  localparam int C_BYTE_OFS_W = 2;
  localparam int C_CNT_W      = 4;

  // Misaligned or beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth_words);
    return (addr[C_BYTE_OFS_W-1:0] != '0) ||
           ({2'b00, addr[31:C_BYTE_OFS_W]} >= depth_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// data_mem_responder_if : request/response handshake bundle for the data memory
// Revision: 1.0
// ============================================================================
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// dmem_array : byte-lane storage, synchronous write, combinational read
// Revision: 1.0
// ============================================================================
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  wire logic                  clk,
  input  wire logic                  we_i,
  input  wire logic [WORD_BYTES-1:0] be_i,
  input  wire logic [ADDR_W-1:0]     addr_i,
  input  wire logic [31:0]           wdata_i,
  output logic      [31:0]           rdata_o
);

  for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
    logic [7:0] lane_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we_i && be_i[g]) begin
        lane_q[addr_i] <= wdata_i[8*g +: 8];
      end
    end

    assign rdata_o[8*g +: 8] = lane_q[addr_i];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : wait-stated load/store target with registered response
// Revision: 1.0
// ============================================================================
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input wire logic            clk,
  input wire logic            rst_n,
  data_mem_responder_if.slave bus
);

  localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_WAIT =
    (WAIT_CYCLES > 0) ? C_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 we_q;
  logic [31:0]          addr_q, wdata_q;
  logic [3:0]           be_q;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 w_access;
  logic                 w_acc_we;
  logic [31:0]          w_acc_addr, w_acc_wdata;
  logic [3:0]           w_acc_be;
  logic                 w_acc_err;
  logic [31:0]          w_mem_rdata;

  // With zero wait states the access happens on the accept edge itself,
  // so the live bus fields feed the array instead of the latched copies.
  assign w_acc_we    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
  assign w_acc_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign w_acc_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
  assign w_acc_be    = (state_q == ST_IDLE) ? bus.req_be    : be_q;
  assign w_acc_err   = addr_err(w_acc_addr, 32'(DEPTH_WORDS));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    w_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cnt_d = '0;
          if (WAIT_CYCLES == 0) begin
            w_access = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == C_LAST_WAIT) begin
          w_access = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_access) begin
      err_d   = w_acc_err;
      rdata_d = (w_acc_err || w_acc_we) ? 32'd0 : w_mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == ST_IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (w_access && w_acc_we && !w_acc_err),
    .be_i    (w_acc_be),
    .addr_i  (w_acc_addr[ADDR_W+1:2]),
    .wdata_i (w_acc_wdata),
    .rdata_o (w_mem_rdata)
  );

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_data_mem_responder : directed table, corner sequences and random traffic
// Revision: 1.0
// ============================================================================
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int W_A   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_responder_if bus_a ();
  data_mem_responder_if bus_b ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mdl [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: word-addressed store with byte merge, error from address rules.
  task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] exp_rd, output logic exp_er);
    int idx;
    logic [31:0] w;
    exp_er = (addr % 4 != 0) || ((addr / 4) >= 32'(DEPTH));
    exp_rd = 32'd0;
    idx    = int'(addr / 4);
    if (!exp_er) begin
      if (we) begin
        w = mdl.exists(idx) ? mdl[idx] : 32'd0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mdl[idx] = w;
      end else begin
        exp_rd = mdl[idx];
      end
    end
  endtask

  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input string tag,
                       output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clk);
    check({tag, " req_ready idle"}, 32'(bus_a.req_ready), 32'd1);
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_be    = be;
    bus_a.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    bus_a.req_we    = 1'($urandom);
    bus_a.req_addr  = $urandom;
    bus_a.req_wdata = $urandom;
    bus_a.req_be    = 4'($urandom);
    lat = 1;
    while (!bus_a.rsp_valid && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(W_A + 1));
    rd = bus_a.rsp_rdata;
    er = bus_a.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held rsp_valid"}, 32'(bus_a.rsp_valid), 32'd1);
      check({tag, " held rdata"}, bus_a.rsp_rdata, rd);
      check({tag, " held req_ready"}, 32'(bus_a.req_ready), 32'd0);
    end
    @(negedge clk);
    bus_a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.rsp_ready = 1'b0;
    check({tag, " rsp_valid after hs"}, 32'(bus_a.rsp_valid), 32'd0);
    check({tag, " req_ready after hs"}, 32'(bus_a.req_ready), 32'd1);
    check({tag, " rdata cleared"}, bus_a.rsp_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd, addr;
    logic        er, exp_er, we;
    logic [31:0] bdata [4];
    int          lat;

    rst_n = 1'b0;
    bus_a.req_valid = 0; bus_a.req_we = 0; bus_a.req_addr = 0; bus_a.req_wdata = 0;
    bus_a.req_be = 0; bus_a.rsp_ready = 0;
    bus_b.req_valid = 0; bus_b.req_we = 0; bus_b.req_addr = 0; bus_b.req_wdata = 0;
    bus_b.req_be = 0; bus_b.rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 32'(bus_a.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("reset rdata", bus_a.rsp_rdata, 32'd0);
    check("reset err", 32'(bus_a.rsp_err), 32'd0);
    check("reset B rsp_valid", 32'(bus_b.rsp_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Directed table: {we, addr, wdata, be, hold, exp_rdata, exp_err}
    vecs.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,       32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h10,       32'h11223344, 4'h5, 0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,       32'h0,        4'hF, 5, 32'hDE22BE44, 1'b0});
    vecs.push_back('{1'b1, 32'h13,       32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h1000,     32'h0,        4'hF, 0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,       32'h0,        4'hF, 0, 32'hDE22BE44, 1'b0});
    vecs.push_back('{1'b1, 32'h20,       32'h0000CAFE, 4'hF, 0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h20,       32'h0,        4'h0, 0, 32'h0000CAFE, 1'b0});
    vecs.push_back('{1'b1, 32'hFFC,      32'h12345678, 4'hF, 0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'hFFFFFFFC, 32'hBADBADBA, 4'hF, 0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'hFFC,      32'h0,        4'hF, 0, 32'h12345678, 1'b0});

    foreach (vecs[i]) begin
      txn_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold,
            $sformatf("vec%0d", i), rd, er);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Reset in WAIT: store to 0x20 must be dropped.
    @(negedge clk);
    bus_a.req_valid = 1; bus_a.req_we = 1; bus_a.req_addr = 32'h20;
    bus_a.req_wdata = 32'hBAD0BAD0; bus_a.req_be = 4'hF;
    @(posedge clk); #1;
    bus_a.req_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("wait-rst req_ready", 32'(bus_a.req_ready), 32'd1);
    check("wait-rst rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("wait-rst rdata", bus_a.rsp_rdata, 32'd0);
    check("wait-rst err", 32'(bus_a.rsp_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("wait-rst no rsp", 32'(bus_a.rsp_valid), 32'd0);
    txn_a(1'b0, 32'h20, 32'h0, 4'hF, 0, "wait-rst load", rd, er);
    check("wait-rst load rdata", rd, 32'h0000CAFE);

    // Reset in RESP: store has already committed.
    @(negedge clk);
    bus_a.req_valid = 1; bus_a.req_we = 1; bus_a.req_addr = 32'h24;
    bus_a.req_wdata = 32'hA5A55A5A; bus_a.req_be = 4'hF;
    @(posedge clk); #1;
    bus_a.req_valid = 0;
    lat = 0;
    while (!bus_a.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("resp-rst reached RESP", 32'(bus_a.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1 check("resp-rst rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    txn_a(1'b0, 32'h24, 32'h0, 4'hF, 0, "resp-rst load", rd, er);
    check("resp-rst load rdata", rd, 32'hA5A55A5A);

    // Zero-wait instance: back-to-back with req_valid held and rsp_ready tied high.
    for (int i = 0; i < 4; i++) bdata[i] = $urandom;
    bus_b.req_valid = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("b2b req_ready", 32'(bus_b.req_ready), 32'd1);
        bus_b.req_we    = (pass == 0);
        bus_b.req_addr  = 32'h40 + 32'(4 * i);
        bus_b.req_wdata = bdata[i];
        bus_b.req_be    = 4'hF;
        @(posedge clk); #1;
        check("b2b rsp_valid", 32'(bus_b.rsp_valid), 32'd1);
        check("b2b rdata", bus_b.rsp_rdata, (pass == 0) ? 32'd0 : bdata[i]);
        check("b2b err", 32'(bus_b.rsp_err), 32'd0);
        @(posedge clk); #1;
        check("b2b idle", 32'(bus_b.rsp_valid), 32'd0);
      end
    end
    bus_b.req_valid = 1'b0;

    // Random traffic against the reference model.
    for (int i = 0; i < 16; i++) begin
      model_txn(1'b1, 32'(4 * i), $urandom, 4'hF, exp_rd, exp_er);
      txn_a(1'b1, 32'(4 * i), mdl[i], 4'hF, 0, "rnd init", rd, er);
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] wd;
      logic [3:0]  be;
      int          sel;
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      be  = 4'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      else if (sel == 1) addr = 32'h1000 + 32'(4 * $urandom_range(0, 1000));
      else if (sel == 2) addr = 32'hFFFF0000 | 32'(4 * $urandom_range(0, 15));
      else               addr = 32'(4 * $urandom_range(0, 15));
      model_txn(we, addr, wd, be, exp_rd, exp_er);
      txn_a(we, addr, wd, be, 0, "rnd", rd, er);
      check($sformatf("rnd%0d rdata @%08h", i, addr), rd, exp_rd);
      check($sformatf("rnd%0d err @%08h", i, addr), 32'(er), 32'(exp_er));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
